// File: rtl/comp_pipe_pkg.sv
// Shared constants and helpers for the comp_pipe compare pipeline and its lanes.
package comp_pipe_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_CNT_WIDTH  = 16;

    // Bits needed to hold a population count of n lanes (0..n inclusive).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/comp_pipe_lane.sv
// comp_lane: one combinational compare channel; exactly one of gt/eq/lt is high.
// SIGNED selects two's-complement ordering, otherwise plain unsigned magnitude.
module comp_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int SIGNED     = 1
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  gt,
    output logic                  eq,
    output logic                  lt
);

    generate
        if (SIGNED != 0) begin : g_signed
            assign gt = $signed(a) > $signed(b);
            assign lt = $signed(a) < $signed(b);
        end else begin : g_unsigned
            assign gt = a > b;
            assign lt = a < b;
        end
    endgenerate

    assign eq = (a == b);

endmodule

// File: rtl/comp_pipe.sv
// comp_pipe: NUM_CH-lane comparator with reductions and a saturating gt event counter.
// 2-cycle latency, 1 beat/cycle; in_ready drops only when both stages are full and out_ready is low.
module comp_pipe
    import comp_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int SIGNED     = 1,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] a,
    input  logic [NUM_CH*DATA_WIDTH-1:0] b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH-1:0]            gt,
    output logic [NUM_CH-1:0]            eq,
    output logic [NUM_CH-1:0]            lt,
    output logic                         any_gt,
    output logic                         all_eq,
    output logic [cnt_w(NUM_CH)-1:0]     gt_count,
    input  logic                         clr_cnt,
    output logic [CNT_WIDTH-1:0]         event_cnt
);

    localparam int GCW  = cnt_w(NUM_CH);
    localparam int SUMW = ((CNT_WIDTH > GCW) ? CNT_WIDTH : GCW) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                         s1_vld_q, s1_vld_d;
    logic [NUM_CH*DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic                         s2_vld_q, s2_vld_d;
    logic [NUM_CH-1:0]            gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic                         any_gt_q, any_gt_d, all_eq_q, all_eq_d;
    logic [GCW-1:0]               gt_count_q, gt_count_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;

    logic [NUM_CH-1:0]            lane_gt, lane_eq, lane_lt;
    logic [GCW-1:0]               lane_pop;
    logic [SUMW-1:0]              cnt_sum;
    logic                         s2_load, s1_load, accept, out_hs;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            comp_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .SIGNED     (SIGNED)
            ) u_lane (
                .a  (a_q[lane_lo(gi, DATA_WIDTH) +: DATA_WIDTH]),
                .b  (b_q[lane_lo(gi, DATA_WIDTH) +: DATA_WIDTH]),
                .gt (lane_gt[gi]),
                .eq (lane_eq[gi]),
                .lt (lane_lt[gi])
            );
        end
    endgenerate

    assign s2_load  = !s2_vld_q || out_ready;
    assign s1_load  = !s1_vld_q || s2_load;
    assign in_ready = s1_load && !rst;
    assign accept   = in_valid && in_ready;
    assign out_hs   = s2_vld_q && out_ready;

    always_comb begin
        lane_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            lane_pop = lane_pop + GCW'(lane_gt[i]);
        end
    end

    always_comb begin
        s1_vld_d   = s1_vld_q;
        a_d        = a_q;
        b_d        = b_q;
        s2_vld_d   = s2_vld_q;
        gt_d       = gt_q;
        eq_d       = eq_q;
        lt_d       = lt_q;
        any_gt_d   = any_gt_q;
        all_eq_d   = all_eq_q;
        gt_count_d = gt_count_q;
        cnt_d      = cnt_q;
        cnt_sum    = SUMW'(cnt_q) + SUMW'(gt_count_q);

        if (s1_load) begin
            s1_vld_d = accept;
        end
        if (accept) begin
            a_d = a;
            b_d = b;
        end

        // Result registers only change when a real beat moves in, so bubbles leave them untouched.
        if (s2_load) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                gt_d       = lane_gt;
                eq_d       = lane_eq;
                lt_d       = lane_lt;
                any_gt_d   = |lane_gt;
                all_eq_d   = &lane_eq;
                gt_count_d = lane_pop;
            end
        end

        if (clr_cnt) begin
            cnt_d = '0;
        end else if (out_hs) begin
            cnt_d = (cnt_sum > SUMW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            gt_q       <= '0;
            eq_q       <= '0;
            lt_q       <= '0;
            any_gt_q   <= 1'b0;
            all_eq_q   <= 1'b0;
            gt_count_q <= '0;
            cnt_q      <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s2_vld_q   <= s2_vld_d;
            gt_q       <= gt_d;
            eq_q       <= eq_d;
            lt_q       <= lt_d;
            any_gt_q   <= any_gt_d;
            all_eq_q   <= all_eq_d;
            gt_count_q <= gt_count_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign out_valid = s2_vld_q;
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign any_gt    = any_gt_q;
    assign all_eq    = all_eq_q;
    assign gt_count  = gt_count_q;
    assign event_cnt = cnt_q;

endmodule

// File: tb/tb_comp_pipe.sv
// Bench for comp_pipe: a signed instance (4-bit counter) and an unsigned instance (16-bit counter) share stimulus.
module tb_comp_pipe;

    typedef struct packed {
        logic [3:0] gt_s, eq_s, lt_s;
        logic [3:0] gt_u, eq_u, lt_u;
        int         acc_cyc;
    } exp_t;

    typedef struct packed {
        logic [31:0] a, b;
        logic [3:0]  gt_s, eq_s, lt_s;
        logic [3:0]  gt_u, eq_u, lt_u;
    } vec_t;

    logic        clk, rst, in_valid, out_ready, clr_cnt;
    logic [31:0] a_in, b_in;
    logic        in_ready_s, out_valid_s, any_gt_s, all_eq_s;
    logic        in_ready_u, out_valid_u, any_gt_u, all_eq_u;
    logic [3:0]  gt_s, eq_s, lt_s, gt_u, eq_u, lt_u;
    logic [2:0]  gc_s, gc_u;
    logic [3:0]  ec_s;
    logic [15:0] ec_u;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    bit   strict = 0;
    bit   seen_stall = 0;
    bit   rnd_done = 0;
    int   cnt_s_exp = 0;
    int   cnt_u_exp = 0;
    exp_t sb[$];

    exp_t m_e;
    bit   m_hs, m_rdy;
    int   m_gcs, m_gcu;

    comp_pipe #(.DATA_WIDTH(8), .NUM_CH(4), .SIGNED(1), .CNT_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a_in), .b(b_in), .out_valid(out_valid_s), .out_ready(out_ready),
        .gt(gt_s), .eq(eq_s), .lt(lt_s), .any_gt(any_gt_s), .all_eq(all_eq_s),
        .gt_count(gc_s), .clr_cnt(clr_cnt), .event_cnt(ec_s)
    );

    comp_pipe #(.DATA_WIDTH(8), .NUM_CH(4), .SIGNED(0), .CNT_WIDTH(16)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .a(a_in), .b(b_in), .out_valid(out_valid_u), .out_ready(out_ready),
        .gt(gt_u), .eq(eq_u), .lt(lt_u), .any_gt(any_gt_u), .all_eq(all_eq_u),
        .gt_count(gc_u), .clr_cnt(clr_cnt), .event_cnt(ec_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pc(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(v[i]);
        return n;
    endfunction

    // Signed order is obtained by biasing the sign bit and comparing as unsigned.
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        logic [7:0] x, y;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            x = av[i*8 +: 8];
            y = bv[i*8 +: 8];
            e.gt_u[i] = x > y;
            e.lt_u[i] = x < y;
            e.eq_u[i] = x == y;
            e.gt_s[i] = (x ^ 8'h80) > (y ^ 8'h80);
            e.lt_s[i] = (x ^ 8'h80) < (y ^ 8'h80);
            e.eq_s[i] = x == y;
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic [31:0] av, input logic [31:0] bv,
                                input logic [3:0] gs, input logic [3:0] es, input logic [3:0] ls,
                                input logic [3:0] gu, input logic [3:0] eu, input logic [3:0] lu);
        vec_t v;
        v.a = av; v.b = bv;
        v.gt_s = gs; v.eq_s = es; v.lt_s = ls;
        v.gt_u = gu; v.eq_u = eu; v.lt_u = lu;
        return v;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input exp_t e);
        bit acc = 0;
        a_in = av;
        b_in = bv;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            if (in_ready_s === 1'b1) begin
                acc = 1;
                e.acc_cyc = cyc;
            end
            @(posedge clk);
            if (acc) sb.push_back(e);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) cycles(1);
        chk("drain_empty", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            m_rdy = !rst && (sb.size() < 2 || out_ready);
            chk("in_ready_s", in_ready_s, m_rdy);
            chk("in_ready_u", in_ready_u, m_rdy);
            if (!in_ready_s && !rst) seen_stall = 1;
            chk("event_cnt_s", ec_s, cnt_s_exp);
            chk("event_cnt_u", ec_u, cnt_u_exp);
            if (rst) begin
                sb.delete();
                cnt_s_exp = 0;
                cnt_u_exp = 0;
            end else begin
                m_hs = 0; m_gcs = 0; m_gcu = 0;
                if (out_valid_s || out_valid_u) begin
                    if (sb.size() == 0) begin
                        chk("spurious_out", {30'd0, out_valid_s, out_valid_u}, 0);
                    end else begin
                        m_e = sb[0];
                        chk("out_valid_s", out_valid_s, 1);
                        chk("out_valid_u", out_valid_u, 1);
                        chk("gt_s", gt_s, m_e.gt_s);
                        chk("eq_s", eq_s, m_e.eq_s);
                        chk("lt_s", lt_s, m_e.lt_s);
                        chk("any_gt_s", any_gt_s, |m_e.gt_s);
                        chk("all_eq_s", all_eq_s, &m_e.eq_s);
                        chk("gt_count_s", gc_s, pc(m_e.gt_s));
                        chk("gt_u", gt_u, m_e.gt_u);
                        chk("eq_u", eq_u, m_e.eq_u);
                        chk("lt_u", lt_u, m_e.lt_u);
                        chk("any_gt_u", any_gt_u, |m_e.gt_u);
                        chk("all_eq_u", all_eq_u, &m_e.eq_u);
                        chk("gt_count_u", gc_u, pc(m_e.gt_u));
                        if (out_ready) begin
                            m_hs = 1;
                            m_gcs = pc(m_e.gt_s);
                            m_gcu = pc(m_e.gt_u);
                            if (strict) chk("latency", cyc - m_e.acc_cyc, 2);
                            void'(sb.pop_front());
                        end
                    end
                end
                if (clr_cnt) begin
                    cnt_s_exp = 0;
                    cnt_u_exp = 0;
                end else if (m_hs) begin
                    cnt_s_exp = (cnt_s_exp + m_gcs > 15) ? 15 : cnt_s_exp + m_gcs;
                    cnt_u_exp = (cnt_u_exp + m_gcu > 65535) ? 65535 : cnt_u_exp + m_gcu;
                end
            end
        end
    end

    vec_t        tbl[6];
    logic [31:0] ra, rb;
    int          t0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        a_in = '0; b_in = '0;

        tbl[0] = mk(32'h7F800500, 32'h807F0501, 4'b1000, 4'b0010, 4'b0101, 4'b0100, 4'b0010, 4'b1001);
        tbl[1] = mk(32'hA5A5A5A5, 32'hA5A5A5A5, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        tbl[2] = mk(32'hFFFFFFFF, 32'h00000000, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        tbl[3] = mk(32'h01020304, 32'h04030201, 4'b0011, 4'b0000, 4'b1100, 4'b0011, 4'b0000, 4'b1100);
        tbl[4] = mk(32'h80008000, 32'h7F7F7F7F, 4'b0000, 4'b0000, 4'b1111, 4'b1010, 4'b0000, 4'b0101);
        tbl[5] = mk(32'hFF7F0180, 32'hFE7F0280, 4'b1000, 4'b0101, 4'b0010, 4'b1000, 4'b0101, 4'b0010);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid_s, 0);
        chk("rst_in_ready", in_ready_s, 0);
        chk("rst_gt", gt_s, 0);
        chk("rst_eq", eq_s, 0);
        chk("rst_lt", lt_s, 0);
        chk("rst_any_gt", any_gt_s, 0);
        chk("rst_all_eq", all_eq_s, 0);
        chk("rst_gt_count", gc_s, 0);
        chk("rst_event_cnt_s", ec_s, 0);
        chk("rst_event_cnt_u", ec_u, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1;

        // Table vectors back to back: 2-cycle latency and one beat per cycle.
        strict = 1;
        t0 = cyc;
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            e = '0;
            e.gt_s = tbl[i].gt_s; e.eq_s = tbl[i].eq_s; e.lt_s = tbl[i].lt_s;
            e.gt_u = tbl[i].gt_u; e.eq_u = tbl[i].eq_u; e.lt_u = tbl[i].lt_u;
            send(tbl[i].a, tbl[i].b, e);
        end
        chk("throughput_cycles", cyc - t0, 6);
        drain();
        strict = 0;

        // Six beats with a three-cycle downstream stall.
        seen_stall = 0;
        fork
            for (int i = 0; i < 6; i++) begin
                ra = $urandom; rb = $urandom;
                send(ra, rb, model(ra, rb));
            end
            begin
                cycles(2);
                out_ready = 1'b0;
                cycles(3);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_seen", seen_stall, 1);

        // Saturation: 5 all-gt beats into a cleared 4-bit counter.
        clr_cnt = 1'b1;
        cycles(1);
        clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h05050505, 32'h01010101, model(32'h05050505, 32'h01010101));
        drain();
        cycles(1);
        chk("sat_event_cnt_s", ec_s, 15);
        chk("sat_event_cnt_u", ec_u, 20);

        // Clear coinciding with a gt_count=3 handshake.
        send(32'h00050505, 32'h00010101, model(32'h00050505, 32'h00010101));
        cycles(1);
        clr_cnt = 1'b1;
        @(negedge clk);
        chk("clr_hs_valid", out_valid_s, 1);
        chk("clr_hs_gt_count", gc_s, 3);
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_event_cnt_s", ec_s, 0);
        chk("clr_event_cnt_u", ec_u, 0);
        @(posedge clk);
        #1;

        // Random beats with random idle gaps and downstream stalls.
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0) cycles(1);
                    ra = $urandom; rb = $urandom;
                    for (int j = 0; j < 4; j++) begin
                        if ($urandom_range(0, 3) == 0) rb[j*8 +: 8] = ra[j*8 +: 8];
                    end
                    send(ra, rb, model(ra, rb));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    cycles(1);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // One-cycle reset with two beats in flight.
        send(32'h10101010, 32'h01010101, model(32'h10101010, 32'h01010101));
        send(32'h20202020, 32'h02020202, model(32'h20202020, 32'h02020202));
        out_ready = 1'b0;
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rstmid_out_valid_s", out_valid_s, 0);
        chk("rstmid_out_valid_u", out_valid_u, 0);
        chk("rstmid_event_cnt_s", ec_s, 0);
        @(posedge clk);
        #1;
        strict = 1;
        send(32'h80808080, 32'h7F7F7F7F, model(32'h80808080, 32'h7F7F7F7F));
        drain();
        strict = 0;
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comp_pipe.md
COMP_PIPE -- requirements
Module: comp_pipe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the operand width per channel.
REQ-002 The block SHALL have parameter NUM_CH, default 4, giving the number of parallel compare channels (1..32).
REQ-003 The block SHALL have parameter SIGNED, default 1; 1 selects two's-complement compare and 0 selects unsigned compare.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the gt event counter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock. All state updates on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the operand beat is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-009 The block SHALL have port a, input, NUM_CH*DATA_WIDTH bits: channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 The block SHALL have port b, input, NUM_CH*DATA_WIDTH bits: packed the same way as a.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the result beat is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have ports gt, eq and lt, each an output of NUM_CH bits: per-channel results.
REQ-014 The block SHALL have port any_gt, output, 1 bit: the OR of gt.
REQ-015 The block SHALL have port all_eq, output, 1 bit: the AND of eq.
REQ-016 The block SHALL have port gt_count, output, clog2(NUM_CH+1) bits: the population count of gt.
REQ-017 The block SHALL have port clr_cnt, input, 1 bit: synchronous clear of the event counter.
REQ-018 The block SHALL have port event_cnt, output, CNT_WIDTH bits: the running total of gt_count over all delivered beats, saturating.

Function
REQ-019 Per channel, exactly one of gt, eq and lt SHALL be 1 in every valid result, with a>b, a==b and a<b evaluated per SIGNED.
REQ-020 The pipeline SHALL have two stages. S1 registers a and b. S2 registers the per-channel results and the reductions.
REQ-021 Latency SHALL be 2 cycles from an accepted input beat (in_valid && in_ready) to out_valid with no backpressure.
REQ-022 Throughput SHALL be 1 beat per cycle while out_ready is held at 1.
REQ-023 Stage advance rule: S2 loads when !s2_valid || out_ready; S1 loads when !s1_valid || (S2 loads).
REQ-024 in_ready SHALL equal (!s1_valid || S2 loads) && !rst, and SHALL be combinational from out_ready.
REQ-025 While out_valid && !out_ready, gt, eq, lt, any_gt, all_eq and gt_count SHALL hold stable; no beat is lost or duplicated.
REQ-026 When in_valid=0, a bubble SHALL propagate; out_valid deasserts after the last beat is consumed.
REQ-027 event_cnt SHALL add gt_count on each output handshake (out_valid && out_ready) and saturate at 2^CNT_WIDTH-1 with no wrap.
REQ-028 When clr_cnt and a handshake occur in the same cycle, clr_cnt SHALL win and event_cnt becomes 0.
REQ-029 Boundary: the most-negative value against the most-positive value SHALL give lt when SIGNED=1 and gt when SIGNED=0.

Reset
REQ-030 When rst=1 at a clock edge: s1_valid, s2_valid, out_valid, gt, eq, lt, any_gt, all_eq, gt_count and event_cnt SHALL become 0.
REQ-031 Reset mid-operation SHALL discard in-flight beats with no output handshake for them. The first beat accepted after rst falls appears 2 cycles later.

Structure
REQ-032 A shared package SHALL hold the clog2-based count-width function, the default DATA_WIDTH/NUM_CH/CNT_WIDTH constants, and the lane-slice helper.
REQ-033 A combinational sub-module comp_lane (one channel: a, b -> gt, eq, lt, parameter SIGNED) SHALL be instantiated NUM_CH times. All sequential logic stays in comp_pipe.

Verification (DATA_WIDTH=8, NUM_CH=4)
REQ-034 Signed: a={0x7F,0x80,0x05,0x00}, b={0x80,0x7F,0x05,0x01}, SIGNED=1 -> gt=4'b1000, eq=4'b0010, lt=4'b0101, gt_count=1, at cycle +2.
REQ-035 Same beat with SIGNED=0 -> gt=4'b0100, lt=4'b1001, eq=4'b0010.
REQ-036 Backpressure: stream 6 beats with out_ready low for cycles 3-5 -> in_ready drops once both stages are full, outputs are held, and all 6 results arrive in order exactly once.
REQ-037 Saturation: CNT_WIDTH=4, 5 beats each with all channels gt -> event_cnt = 4, 8, 12, 15, 15.
REQ-038 clr_cnt asserted on the same cycle as a handshake with gt_count=3 -> event_cnt=0 next cycle.
REQ-039 rst pulsed for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, neither beat delivered, and a new beat appears 2 cycles after acceptance.
